// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants and the round-key store state type.
package aes_pkg;
    localparam int AES_BLOCK_LEN = 128;
    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;
    typedef enum logic [1:0] {EMPTY, LOADING, READY, STREAM} rk_state_e;
endpackage

// File: rtl/aes_rk_regfile.sv
// aes_rk_regfile: round-key storage, one synchronous write port, one combinational read port.
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port. Contents are not reset.
module aes_rk_regfile #(
    parameter int DEPTH = 15,
    parameter int W     = 128,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/aes_round_key_store.sv
// aes_round_key_store: buffers an expanded AES key schedule and replays it ascending or descending.
// Ports: clk/reset; load_* accept round keys (nr_cfg sampled on first beat); start/decrypt launch a
// replay; rk_* stream keys with valid/ready; keys_ready flags a stored schedule; err is a sticky load error.
module aes_round_key_store import aes_pkg::*; #(
    parameter int BLOCK_LEN     = AES_BLOCK_LEN,
    parameter int NUMS_OF_ROUND = 14,
    parameter int IDX_W         = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IDX_W-1:0]     nr_cfg,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [BLOCK_LEN-1:0] load_key,
    input  logic                 load_last,
    input  logic                 start,
    input  logic                 decrypt,
    output logic                 rk_valid,
    input  logic                 rk_ready,
    output logic [BLOCK_LEN-1:0] rk_out,
    output logic [IDX_W-1:0]     rk_idx,
    output logic                 rk_last,
    output logic                 keys_ready,
    output logic                 err
);
    rk_state_e            state_q, state_d;
    logic [IDX_W-1:0]     nr_q, nr_d, wp_q, wp_d, rp_q, rp_d, rk_idx_q, rk_idx_d;
    logic                 dec_q, dec_d, err_q, err_d, ld_en_q, ld_en_d;
    logic                 rk_valid_q, rk_valid_d, rk_last_q, rk_last_d;
    logic [BLOCK_LEN-1:0] rk_out_q, rk_out_d, rd_data;
    logic                 load_hs, nr_ok, we, present;
    logic [IDX_W-1:0]     waddr;

    aes_rk_regfile #(.DEPTH(NUMS_OF_ROUND + 1), .W(BLOCK_LEN), .AW(IDX_W)) u_rf (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (load_key),
        .raddr (rp_d),
        .rdata (rd_data)
    );

    // load_ready stays low until the first clock after reset release
    assign load_ready = ld_en_q && state_q != STREAM;
    assign load_hs    = load_valid && load_ready;
    assign nr_ok      = nr_cfg == IDX_W'(NR_128) || nr_cfg == IDX_W'(NR_192) || nr_cfg == IDX_W'(NR_256);
    assign keys_ready = state_q == READY || state_q == STREAM;
    assign rk_valid   = rk_valid_q;
    assign rk_out     = rk_out_q;
    assign rk_idx     = rk_idx_q;
    assign rk_last    = rk_last_q;
    assign err        = err_q;

    always_comb begin
        state_d    = state_q;
        nr_d       = nr_q;
        wp_d       = wp_q;
        rp_d       = rp_q;
        dec_d      = dec_q;
        err_d      = err_q;
        ld_en_d    = 1'b1;
        rk_valid_d = rk_valid_q;
        rk_out_d   = rk_out_q;
        rk_idx_d   = rk_idx_q;
        rk_last_d  = rk_last_q;
        we         = 1'b0;
        waddr      = wp_q;
        present    = 1'b0;
        case (state_q)
            EMPTY, READY: begin
                // a load beat here is always a first beat, and it beats a simultaneous start
                if (load_hs) begin
                    if (nr_ok) begin
                        we      = 1'b1;
                        waddr   = '0;
                        nr_d    = nr_cfg;
                        wp_d    = IDX_W'(1);
                        err_d   = 1'b0;
                        state_d = LOADING;
                    end else begin
                        err_d   = 1'b1;
                        state_d = EMPTY;
                    end
                end else if (state_q == READY && start) begin
                    dec_d   = decrypt;
                    rp_d    = decrypt ? nr_q : '0;
                    present = 1'b1;
                    state_d = STREAM;
                end
            end
            LOADING: begin
                if (load_hs) begin
                    we   = 1'b1;
                    wp_d = wp_q + 1'b1;
                    if (load_last && wp_q == nr_q) begin
                        state_d = READY;
                    end else if (load_last || wp_q == nr_q) begin
                        err_d   = 1'b1;
                        state_d = EMPTY;
                    end
                end
            end
            STREAM: begin
                if (rk_valid_q && rk_ready) begin
                    if (rk_last_q) begin
                        rk_valid_d = 1'b0;
                        state_d    = READY;
                    end else begin
                        rp_d    = dec_q ? rp_q - 1'b1 : rp_q + 1'b1;
                        present = 1'b1;
                    end
                end
            end
        endcase
        // read port is addressed by rp_d so the next key is registered in the same cycle it is chosen
        if (present) begin
            rk_valid_d = 1'b1;
            rk_out_d   = rd_data;
            rk_idx_d   = rp_d;
            rk_last_d  = rp_d == (dec_d ? {IDX_W{1'b0}} : nr_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            nr_q       <= '0;
            wp_q       <= '0;
            rp_q       <= '0;
            dec_q      <= 1'b0;
            err_q      <= 1'b0;
            ld_en_q    <= 1'b0;
            rk_valid_q <= 1'b0;
            rk_out_q   <= '0;
            rk_idx_q   <= '0;
            rk_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            nr_q       <= nr_d;
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            dec_q      <= dec_d;
            err_q      <= err_d;
            ld_en_q    <= ld_en_d;
            rk_valid_q <= rk_valid_d;
            rk_out_q   <= rk_out_d;
            rk_idx_q   <= rk_idx_d;
            rk_last_q  <= rk_last_d;
        end
    end
endmodule

// File: tb/tb_aes_round_key_store.sv
// tb_aes_round_key_store: directed test of the round-key store against a transaction-level model.
module tb_aes_round_key_store;
    localparam int BL = 128;
    localparam int IW = 4;
    localparam int P_EMPTY = 0, P_LOAD = 1, P_READY = 2, P_STREAM = 3;

    logic          clk = 1'b0, reset = 1'b1;
    logic [IW-1:0] nr_cfg = '0;
    logic          load_valid = 1'b0, load_last = 1'b0, start = 1'b0, decrypt = 1'b0, rk_ready = 1'b0;
    logic [BL-1:0] load_key = '0;
    logic          load_ready, rk_valid, rk_last, keys_ready, err;
    logic [BL-1:0] rk_out;
    logic [IW-1:0] rk_idx;

    always #5 clk = ~clk;

    aes_round_key_store #(.BLOCK_LEN(BL), .NUMS_OF_ROUND(14), .IDX_W(IW)) dut (
        .clk        (clk),
        .reset      (reset),
        .nr_cfg     (nr_cfg),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_key   (load_key),
        .load_last  (load_last),
        .start      (start),
        .decrypt    (decrypt),
        .rk_valid   (rk_valid),
        .rk_ready   (rk_ready),
        .rk_out     (rk_out),
        .rk_idx     (rk_idx),
        .rk_last    (rk_last),
        .keys_ready (keys_ready),
        .err        (err)
    );

    logic [127:0] aes_rk [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    int vecs = 0, errs = 0;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // model: stored keys, the schedule length, and the queue of indices still to be replayed
    int           m_phase = P_EMPTY;
    logic [127:0] m_keys [15];
    int           m_nr = 0, m_wp = 0;
    logic         m_err = 1'b0, m_en = 1'b0;
    bit           m_lh;
    int           m_q [$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = P_EMPTY;
            m_err   = 1'b0;
            m_en    = 1'b0;
            m_wp    = 0;
            m_q.delete();
        end else begin
            m_lh = load_valid && m_en && m_phase != P_STREAM;
            if (m_lh && (m_phase == P_EMPTY || m_phase == P_READY)) begin
                if (nr_cfg inside {4'd10, 4'd12, 4'd14}) begin
                    m_keys[0] = load_key;
                    m_nr      = int'(nr_cfg);
                    m_wp      = 1;
                    m_err     = 1'b0;
                    m_phase   = P_LOAD;
                end else begin
                    m_err   = 1'b1;
                    m_phase = P_EMPTY;
                end
            end else if (m_lh && m_phase == P_LOAD) begin
                m_keys[m_wp] = load_key;
                if (load_last && m_wp == m_nr) m_phase = P_READY;
                else if (load_last || m_wp == m_nr) begin
                    m_err   = 1'b1;
                    m_phase = P_EMPTY;
                end else m_wp++;
            end else if (m_phase == P_READY && start) begin
                for (int i = 0; i <= m_nr; i++) m_q.push_back(decrypt ? m_nr - i : i);
                m_phase = P_STREAM;
            end else if (m_phase == P_STREAM && rk_ready) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_phase = P_READY;
            end
            m_en = 1'b1;
        end
    end

    logic chk_en = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("load_ready", load_ready, m_en && m_phase != P_STREAM);
            check("keys_ready", keys_ready, m_phase == P_READY || m_phase == P_STREAM);
            check("err", err, m_err);
            check("rk_valid", rk_valid, m_q.size() > 0);
            if (m_q.size() > 0) begin
                check("rk_idx", rk_idx, m_q[0]);
                check("rk_out", rk_out, m_keys[m_q[0]]);
                check("rk_last", rk_last, m_q.size() == 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(int nr, int from, int n, int last_at, bit use_aes);
        for (int i = from; i < n; i++) begin
            load_valid = 1'b1;
            nr_cfg     = IW'(nr);
            load_key   = use_aes ? aes_rk[i] : {96'h0123456789abcdef01234567, 32'(i)};
            load_last  = (i == last_at);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // mode 0: always ready, 1: toggling, 2: random
    task automatic drain(int mode);
        for (int c = 0; c < 100 && m_phase == P_STREAM; c++) begin
            rk_ready = mode == 0 ? 1'b1 : mode == 1 ? ~rk_ready : 1'($urandom_range(0, 1));
            tick();
        end
        rk_ready = 1'b0;
        check("replay_done", rk_valid, 1'b0);
    endtask

    task automatic launch(bit dec);
        start   = 1'b1;
        decrypt = dec;
        tick();
        start = 1'b0;
    endtask

    initial begin
        tick();
        check("rst_load_ready", load_ready, 1'b0);
        check("rst_rk_valid", rk_valid, 1'b0);
        check("rst_rk_out", rk_out, 128'h0);
        check("rst_rk_idx", rk_idx, 4'd0);
        check("rst_rk_last", rk_last, 1'b0);
        check("rst_keys_ready", keys_ready, 1'b0);
        check("rst_err", err, 1'b0);
        chk_en = 1'b1;
        reset  = 1'b0;
        tick();
        check("post_rst_load_ready", load_ready, 1'b1);

        // unsupported round count is discarded
        load(11, 0, 1, 0, 1'b0);
        check("bad_nr_err", err, 1'b1);
        check("bad_nr_keys_ready", keys_ready, 1'b0);
        check("bad_nr_load_ready", load_ready, 1'b1);

        // AES-128 schedule, ascending replay at full rate
        load(10, 0, 11, 10, 1'b1);
        check("aes_err_cleared", err, 1'b0);
        check("aes_keys_ready", keys_ready, 1'b1);
        rk_ready = 1'b1;
        launch(1'b0);
        check("enc_first_idx", rk_idx, 4'd0);
        check("enc_first_key", rk_out, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        check("enc_first_last", rk_last, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        check("enc_last_idx", rk_idx, 4'd10);
        check("enc_last_key", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("enc_last_flag", rk_last, 1'b1);
        tick();
        check("enc_done_valid", rk_valid, 1'b0);
        check("enc_done_keys_ready", keys_ready, 1'b1);
        rk_ready = 1'b0;

        // descending replay with stalls
        launch(1'b1);
        check("dec_first_idx", rk_idx, 4'd10);
        check("dec_first_key", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        drain(1);
        check("dec_done_keys_ready", keys_ready, 1'b1);
        check("dec_done_load_ready", load_ready, 1'b1);

        // early load_last on an AES-256 schedule, then a good one
        load(14, 0, 9, 8, 1'b0);
        check("early_last_err", err, 1'b1);
        check("early_last_keys_ready", keys_ready, 1'b0);
        check("early_last_load_ready", load_ready, 1'b1);
        load(14, 0, 15, 14, 1'b0);
        check("nr14_err", err, 1'b0);
        check("nr14_keys_ready", keys_ready, 1'b1);
        launch(1'b0);
        drain(2);
        launch(1'b1);
        drain(2);

        // reset mid-stream
        load(10, 0, 11, 10, 1'b1);
        rk_ready = 1'b1;
        launch(1'b0);
        for (int i = 0; i < 5; i++) tick();
        check("mid_idx", rk_idx, 4'd5);
        check("mid_key", rk_out, 128'hd4d1c6f87c839d87caf2b8bc11f915bc);
        reset = 1'b1;
        #1;
        check("abort_valid", rk_valid, 1'b0);
        check("abort_keys_ready", keys_ready, 1'b0);
        check("abort_load_ready", load_ready, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        launch(1'b0);
        for (int i = 0; i < 3; i++) begin
            check("no_replay_after_reset", rk_valid, 1'b0);
            tick();
        end
        rk_ready = 1'b0;

        // start colliding with a load beat in READY: the load wins
        load(10, 0, 11, 10, 1'b1);
        start      = 1'b1;
        decrypt    = 1'b0;
        load_valid = 1'b1;
        nr_cfg     = 4'd10;
        load_key   = aes_rk[0];
        tick();
        start      = 1'b0;
        load_valid = 1'b0;
        check("collide_keys_ready", keys_ready, 1'b0);
        check("collide_valid", rk_valid, 1'b0);
        check("collide_load_ready", load_ready, 1'b1);
        tick();
        check("collide_valid2", rk_valid, 1'b0);
        load(10, 1, 11, 10, 1'b1);
        check("collide_reload", keys_ready, 1'b1);
        launch(1'b1);
        drain(2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/aes_round_key_store.md
Name: aes_round_key_store

Overview:
- Sits directly downstream of key expansion. Accepts expanded 128-bit round keys one per beat and buffers up to NUMS_OF_ROUND+1 of them.
- Replays the stored keys to the cipher/inverse-cipher round datapath, one key per handshake.
- Replay order is ascending for encryption and descending for decryption.
- Decouples key-schedule timing from data-path timing, so one expanded key serves many blocks.

Parameters:
- BLOCK_LEN, 128, round-key and AES state width (fixed by the standard).
- NUMS_OF_ROUND, 14, maximum round count supported; storage depth is NUMS_OF_ROUND+1.
- IDX_W, 4, width of the round index; must satisfy 2^IDX_W > NUMS_OF_ROUND.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- nr_cfg  input  IDX_W  round count for the key being loaded (10/12/14); sampled on the first load beat only.
- load_valid  input  1  load_key is valid.
- load_ready  output  1  store accepts a load beat.
- load_key  input  BLOCK_LEN  round key for the current write index.
- load_last  input  1  marks the final round key of the schedule.
- start  input  1  one-cycle request to replay the stored schedule.
- decrypt  input  1  replay order, sampled with start: 0 = ascending, 1 = descending.
- rk_valid  output  1  rk_out is valid.
- rk_ready  input  1  consumer accepts rk_out.
- rk_out  output  BLOCK_LEN  registered round key.
- rk_idx  output  IDX_W  round index of rk_out.
- rk_last  output  1  rk_out is the final key of this replay.
- keys_ready  output  1  a complete schedule is stored.
- err  output  1  sticky load error; cleared only by reset or by the next accepted first beat.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to EMPTY.
  - load_ready=0 while reset is asserted, 1 from the first cycle after release.
  - rk_valid=0, rk_out=0, rk_idx=0, rk_last=0, keys_ready=0, err=0; write and read pointers cleared.
  - Key storage contents are not reset.
- States: EMPTY, LOADING, READY, STREAM.
- A load handshake is load_valid && load_ready. A replay handshake is rk_valid && rk_ready.
- EMPTY:
  - load_ready=1.
  - First handshake: if nr_cfg is not one of 10/12/14, set err, discard the beat and stay in EMPTY.
  - Otherwise latch nr, write key to index 0, clear err, wp=1, go to LOADING.
- LOADING:
  - load_ready=1; each handshake writes storage[wp] and then wp++.
  - load_last on the beat with wp==nr: go to READY next cycle; keys_ready=1 that cycle.
  - load_last with wp<nr, or a beat with wp==nr and no load_last: set err and return to EMPTY. The schedule is invalid.
- READY:
  - keys_ready=1, load_ready=1.
  - A load handshake restarts loading as a first beat and drops keys_ready the next cycle; the new nr_cfg is sampled.
  - start with no simultaneous load beat: latch decrypt, set rp = decrypt ? nr : 0, go to STREAM.
  - start and a load beat in the same cycle: the load wins and start is dropped.
- STREAM:
  - load_ready=0; start is ignored.
  - Latency: start at cycle t gives rk_valid=1 at t+1, with rk_out=storage[rp] and rk_idx=rp.
  - rk_last=1 when rp == (decrypt ? 0 : nr).
  - rk_out, rk_idx and rk_last are held stable while rk_valid && !rk_ready.
  - Each non-last handshake steps rp by ±1 and presents the next key the following cycle, so back-to-back throughput is one key per cycle.
  - Handshake on rk_last: rk_valid=0 next cycle, state returns to READY; keys_ready stays 1.
- Reset mid-load or mid-stream aborts immediately. keys_ready=0, so a new full load is required.
- Storage is a register array written only in EMPTY/LOADING/READY, so reads in STREAM never collide with writes.

Decomposition:
- aes_pkg holds:
  - AES_BLOCK_LEN=128.
  - Round-count constants NR_128=10, NR_192=12, NR_256=14.
  - Round-key state enum {EMPTY, LOADING, READY, STREAM}.
- One natural sub-module, aes_rk_regfile: (NUMS_OF_ROUND+1) x BLOCK_LEN storage with one synchronous write port and one combinational read port.
- The FSM and pointers stay in the top module.

Test Plan:
- Load all 11 round keys of the AES-128 standard key 2b7e151628aed2a6abf7158809cf4f3c (idx0 = that value, idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6) with nr_cfg=10, then start with decrypt=0 and rk_ready=1 -> 11 consecutive beats, rk_idx 0..10, rk_out matching each loaded key, rk_last only on idx10, keys_ready=1 throughout.
- Same schedule, start with decrypt=1, rk_ready toggling 1/0 -> rk_idx 10 down to 0, outputs stable during stalls, rk_last on idx0, state back to READY.
- nr_cfg=14, assert load_last on the 9th beat -> err=1, keys_ready=0, load_ready=1 (EMPTY); a subsequent valid 15-beat load clears err and sets keys_ready.
- nr_cfg=11 on the first beat -> beat discarded, err=1, state stays EMPTY.
- Assert reset for 1 cycle during STREAM at idx 5 -> rk_valid=0 and keys_ready=0 immediately; start afterwards produces no rk_valid.
- In READY, assert start and load_valid together -> no replay; loading restarts and keys_ready=0 the next cycle.
